// File: rtl/exc_ctrl_seq.sv
// Sequential exception controller: sticky per-source pending capture, fixed-priority
// arbitration with single-step trap, EPC/cause capture, flush/redirect and ERET return.
module exc_ctrl_seq #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CAUSE_W    = 3,
  parameter int unsigned SS_LIMIT   = 400,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(32'h0000_0200)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      exc_req,
  input  logic [NUM_SRC*PC_W-1:0] exc_epc,
  input  logic [NUM_SRC-1:0]      exc_mask,
  input  logic                    ss_en,
  input  logic                    ss_valid,
  input  logic [PC_W-1:0]         ss_pc,
  input  logic                    eret,
  output logic [PC_W-1:0]         epc,
  output logic [CAUSE_W-1:0]      cause,
  output logic                    epc_we,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [PC_W-1:0]         redirect_pc,
  output logic                    in_handler,
  output logic                    ss_trap,
  output logic [NUM_SRC-1:0]      pending
);

  if ((1 << CAUSE_W) < (NUM_SRC + 2)) begin : g_cause_w_check
    $error("exc_ctrl_seq: CAUSE_W cannot encode NUM_SRC+2 cause values");
  end

  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_HANDLER, S_RETURN} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     epc_q, epc_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic                epc_we_q, epc_we_d;
  logic                flush_q, flush_d;
  logic                rv_q, rv_d;
  logic [PC_W-1:0]     rpc_q, rpc_d;
  logic                in_handler_q, in_handler_d;
  logic                ss_trap_q, ss_trap_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  win_oh_q, win_oh_d;
  logic [PC_W-1:0]     epc_hold_q [NUM_SRC];
  logic [PC_W-1:0]     epc_hold_d [NUM_SRC];

  logic [NUM_SRC-1:0]  elig;
  logic [NUM_SRC-1:0]  win_oh;
  logic [CAUSE_W-1:0]  win_cause;
  logic [PC_W-1:0]     win_epc;
  logic [NUM_SRC-1:0]  clr;
  logic                ss_ok;

  // Arbitration, FSM next-state and registered-output next values
  always_comb begin
    elig      = pending_q & ~exc_mask;
    win_oh    = '0;
    win_cause = '0;
    win_epc   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_cause = CAUSE_W'(i + 1);
        win_epc   = epc_hold_q[i];
      end
    end
    ss_ok = ss_en && ss_valid && (ss_pc < PC_W'(SS_LIMIT)) &&
            (elig == '0) && (state_q == S_IDLE);

    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    epc_we_d     = 1'b0;
    flush_d      = 1'b0;
    rv_d         = 1'b0;
    rpc_d        = rpc_q;
    in_handler_d = in_handler_q;
    ss_trap_d    = ss_trap_q;
    win_oh_d     = win_oh_q;
    clr          = '0;

    case (state_q)
      S_IDLE: begin
        if ((elig != '0) || ss_ok) begin
          state_d      = S_TAKE;
          epc_d        = (elig != '0) ? win_epc : ss_pc;
          cause_d      = (elig != '0) ? win_cause : CAUSE_W'(NUM_SRC + 1);
          epc_we_d     = 1'b1;
          flush_d      = 1'b1;
          rv_d         = 1'b1;
          rpc_d        = HANDLER_PC;
          in_handler_d = 1'b1;
          ss_trap_d    = (elig == '0);
          win_oh_d     = win_oh;
        end
      end
      S_TAKE: begin
        clr     = win_oh_q;
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (eret) begin
          state_d = S_RETURN;
          rv_d    = 1'b1;
          rpc_d   = epc_q;
        end
      end
      S_RETURN: begin
        state_d      = S_IDLE;
        cause_d      = '0;
        ss_trap_d    = 1'b0;
        in_handler_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // A request in the clearing cycle re-arms the bit
    pending_d = (pending_q & ~clr) | exc_req;
    for (int i = 0; i < NUM_SRC; i++) begin
      epc_hold_d[i] = (exc_req[i] && !pending_q[i]) ? exc_epc[i*PC_W +: PC_W]
                                                    : epc_hold_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      epc_we_q     <= 1'b0;
      flush_q      <= 1'b0;
      rv_q         <= 1'b0;
      rpc_q        <= '0;
      in_handler_q <= 1'b0;
      ss_trap_q    <= 1'b0;
      pending_q    <= '0;
      win_oh_q     <= '0;
      for (int i = 0; i < NUM_SRC; i++) epc_hold_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      epc_we_q     <= epc_we_d;
      flush_q      <= flush_d;
      rv_q         <= rv_d;
      rpc_q        <= rpc_d;
      in_handler_q <= in_handler_d;
      ss_trap_q    <= ss_trap_d;
      pending_q    <= pending_d;
      win_oh_q     <= win_oh_d;
      for (int i = 0; i < NUM_SRC; i++) epc_hold_q[i] <= epc_hold_d[i];
    end
  end

  assign epc            = epc_q;
  assign cause          = cause_q;
  assign epc_we         = epc_we_q;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign in_handler     = in_handler_q;
  assign ss_trap        = ss_trap_q;
  assign pending        = pending_q;

endmodule

// File: tb/tb_exc_ctrl_seq.sv
// Directed bench for exc_ctrl_seq: expected handler entries/returns are queued as stimulus
// is driven and checked by a monitor whenever the DUT raises redirect_valid.
module tb_exc_ctrl_seq;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CAUSE_W = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_SRC-1:0]      exc_req;
  logic [NUM_SRC*PC_W-1:0] exc_epc;
  logic [NUM_SRC-1:0]      exc_mask;
  logic                    ss_en, ss_valid, eret;
  logic [PC_W-1:0]         ss_pc;
  logic [PC_W-1:0]         epc, redirect_pc;
  logic [CAUSE_W-1:0]      cause;
  logic                    epc_we, flush, redirect_valid, in_handler, ss_trap;
  logic [NUM_SRC-1:0]      pending;

  exc_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .exc_req(exc_req), .exc_epc(exc_epc),
    .exc_mask(exc_mask), .ss_en(ss_en), .ss_valid(ss_valid), .ss_pc(ss_pc),
    .eret(eret), .epc(epc), .cause(cause), .epc_we(epc_we), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .in_handler(in_handler), .ss_trap(ss_trap), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         take;
    logic [2:0] cause;
    logic [31:0] epc;
    logic       ss;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  logic prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit take, input logic [2:0] c, input logic [31:0] e, input logic s);
    ev_t ev;
    ev.take = take; ev.cause = c; ev.epc = e; ev.ss = s;
    exp_q.push_back(ev);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every redirect must match the oldest expected event
  always @(negedge clk) begin
    if (redirect_valid) begin
      chk("rv_single_cycle", 32'(prev_rv), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_redirect observed=%0h expected=none", redirect_pc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk(e.take ? "take_cause" : "ret_cause", 32'(cause), 32'(e.cause));
        chk(e.take ? "take_epc" : "ret_epc", epc, e.epc);
        chk(e.take ? "take_rpc" : "ret_rpc", redirect_pc, e.take ? 32'h200 : e.epc);
        chk(e.take ? "take_epc_we" : "ret_epc_we", 32'(epc_we), 32'(e.take));
        chk(e.take ? "take_flush" : "ret_flush", 32'(flush), 32'(e.take));
        chk(e.take ? "take_in_handler" : "ret_in_handler", 32'(in_handler), 32'd1);
        chk(e.take ? "take_ss_trap" : "ret_ss_trap", 32'(ss_trap), 32'(e.ss));
      end
    end
    prev_rv <= redirect_valid;
  end

  initial begin
    rst_n = 1'b0; exc_req = '0; exc_epc = '0; exc_mask = '0;
    ss_en = 1'b0; ss_valid = 1'b0; ss_pc = '0; eret = 1'b0;

    // Reset held two cycles while a request pulses
    exc_req = 3'b001; exc_epc = {32'h0, 32'h0, 32'h0ABC};
    tick(2);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_outs", {27'h0, epc_we, flush, redirect_valid, in_handler, ss_trap}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    rst_n = 1'b1; exc_req = '0;
    tick(3);
    chk("post_rst_pending", 32'(pending), 32'h0);
    chk("post_rst_in_handler", 32'(in_handler), 32'h0);

    // Priority: sources 1 and 2 together, source 1 wins
    exc_epc = {32'h108, 32'h104, 32'h100};
    exc_req = 3'b110;
    push(1'b1, 3'd2, 32'h104, 1'b0);
    tick(1); exc_req = '0;
    tick(2);
    chk("prio_handler_pending", 32'(pending), 32'h4);
    chk("prio_handler_in", 32'(in_handler), 32'h1);
    push(1'b0, 3'd2, 32'h104, 1'b0);
    push(1'b1, 3'd3, 32'h108, 1'b0);
    eret = 1'b1; tick(1); eret = 1'b0;
    tick(3);
    chk("prio2_pending", 32'(pending), 32'h0);
    push(1'b0, 3'd3, 32'h108, 1'b0);
    eret = 1'b1; tick(1); eret = 1'b0;
    tick(2);
    chk("prio_idle_cause", 32'(cause), 32'h0);
    chk("prio_idle_in", 32'(in_handler), 32'h0);

    // Mask: blocked source stays pending, taken one edge after unmask
    exc_mask = 3'b001; exc_epc = {32'h0, 32'h0, 32'h300}; exc_req = 3'b001;
    tick(1); exc_req = '0;
    tick(10);
    chk("mask_pending", 32'(pending), 32'h1);
    chk("mask_no_take", 32'(in_handler), 32'h0);
    push(1'b1, 3'd1, 32'h300, 1'b0);
    exc_mask = '0;
    tick(1);
    chk("unmask_flush", 32'(flush), 32'h1);
    tick(1);
    chk("unmask_flush_drop", 32'(flush), 32'h0);
    push(1'b0, 3'd1, 32'h300, 1'b0);
    eret = 1'b1; tick(1); eret = 1'b0;
    tick(2);

    // Single-step boundary: 399 traps, 400 does not
    ss_en = 1'b1; ss_valid = 1'b1; ss_pc = 32'd399;
    push(1'b1, 3'd4, 32'd399, 1'b1);
    tick(1); ss_valid = 1'b0;
    chk("ss_trap_take", 32'(ss_trap), 32'h1);
    tick(1);
    push(1'b0, 3'd4, 32'd399, 1'b1);
    eret = 1'b1; tick(1); eret = 1'b0;
    tick(1);
    chk("ss_trap_clear", 32'(ss_trap), 32'h0);
    ss_valid = 1'b1; ss_pc = 32'd400;
    tick(5);
    ss_valid = 1'b0;
    chk("ss_limit_no_take", 32'(in_handler), 32'h0);
    ss_en = 1'b0;

    // No nesting: request during eret is taken only after the return
    exc_epc = {32'h0, 32'h500, 32'h600}; exc_req = 3'b010;
    push(1'b1, 3'd2, 32'h500, 1'b0);
    tick(1); exc_req = '0;
    tick(2);
    push(1'b0, 3'd2, 32'h500, 1'b0);
    push(1'b1, 3'd1, 32'h600, 1'b0);
    exc_req = 3'b001; eret = 1'b1;
    tick(1); exc_req = '0; eret = 1'b0;
    chk("nest_ret_pending", 32'(pending), 32'h1);
    tick(3);
    chk("nest_handler_cause", 32'(cause), 32'h1);

    // Reset in the middle of a handler with a pending request
    exc_epc = {32'h0, 32'h0, 32'h700}; exc_req = 3'b001;
    tick(1); exc_req = '0;
    chk("midrst_pre_pending", 32'(pending), 32'h1);
    chk("midrst_pre_in", 32'(in_handler), 32'h1);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk("midrst_in", 32'(in_handler), 32'h0);
    chk("midrst_pending", 32'(pending), 32'h0);
    chk("midrst_cause", 32'(cause), 32'h0);
    tick(5);
    chk("midrst_idle_in", 32'(in_handler), 32'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exc_ctrl_seq.md
Name: exc_ctrl_seq

Overview:
- Sequential, parametrised exception controller for the multi-cycle/pipelined MIPS core.
- Latches exception requests from NUM_SRC sources and a single-step trap, then arbitrates by fixed priority.
- For the winning event it captures EPC and cause, flushes the pipeline, redirects fetch to the handler, and sequences the return on ERET.
- Adds sticky pending state, per-source masking, no-nesting protection and a registered handshake. None of these exist in the earlier purely combinational exception logic.

Parameters:
- NUM_SRC, 3: number of exception sources. Index 0 has highest priority.
- PC_W, 32: PC/EPC width.
- CAUSE_W, 3: cause code width. Must satisfy 2^CAUSE_W >= NUM_SRC+2; elaboration fails otherwise.
- SS_LIMIT, 400: single-step traps are taken only when ss_pc < SS_LIMIT (unsigned compare).
- HANDLER_PC, 32'h0000_0200: redirect target on exception entry.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- exc_req  in  NUM_SRC  per-source exception request pulse or level.
- exc_epc  in  NUM_SRC*PC_W  EPC candidate per source; slice i belongs to source i. Sampled with exc_req[i].
- exc_mask  in  NUM_SRC  1 = source i is blocked from being taken; it stays pending.
- ss_en  in  1  single-step mode enable.
- ss_valid  in  1  an instruction retired this cycle.
- ss_pc  in  PC_W  PC+4 of the retiring instruction.
- eret  in  1  return-from-exception strobe.
- epc  out  PC_W  exception PC register.
- cause  out  CAUSE_W  cause register. 0 = none; i+1 = source i; NUM_SRC+1 = single-step.
- epc_we  out  1  one-cycle pulse when epc/cause are written.
- flush  out  1  one-cycle pipeline flush.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  PC_W  redirect target; valid while redirect_valid=1.
- in_handler  out  1  high from TAKE through RETURN.
- ss_trap  out  1  high while the current handler entry was caused by single-step.
- pending  out  NUM_SRC  sticky pending vector.

Behaviour:
- All registers update on the rising edge of clk. Reset (rst_n=0 at an edge) forces:
  - state=IDLE;
  - epc=0, cause=0, pending=0;
  - epc_we, flush, redirect_valid, in_handler, ss_trap all 0;
  - redirect_pc=0.
- Reset wins over every other event, including mid-handler.
- Pending capture, every cycle in every state:
  - pending[i] <= pending[i] | exc_req[i].
  - An epc_hold[i] register loads exc_epc slice i only when exc_req[i]=1 and pending[i]=0. The first request's EPC is kept; repeats are absorbed.
- Eligible set: elig = pending & ~exc_mask. Winner = lowest set index of elig.
- Single-step is eligible only when all of the following hold: ss_en=1, ss_valid=1, ss_pc < SS_LIMIT, elig=0, and state=IDLE. It is lowest priority and not sticky.
- FSM states are IDLE, TAKE, HANDLER and RETURN:
  - IDLE: if elig≠0 or single-step is eligible, go to TAKE next cycle. Register the winner id there; there is 1 cycle of latency from the request being visible in pending.
  - TAKE (1 cycle):
    - epc <= epc_hold[winner] (or ss_pc for single-step); cause <= winner+1 (or NUM_SRC+1).
    - epc_we=1, flush=1, redirect_valid=1, redirect_pc=HANDLER_PC.
    - Clear pending[winner]. A new exc_req on the winner in this same cycle re-sets the bit, because set beats clear.
    - ss_trap <= single-step winner. Then go to HANDLER.
  - HANDLER: in_handler=1. No new exception is taken (no nesting), but requests keep accumulating in pending. On eret=1, go to RETURN.
  - RETURN (1 cycle):
    - redirect_valid=1, redirect_pc=epc, in_handler=1; then go to IDLE.
    - cause clears to 0 and ss_trap to 0 on the edge leaving RETURN.
    - If elig≠0 in the IDLE cycle that follows, the next exception is taken: back-to-back entry with no lost requests.
- eret in IDLE, TAKE or RETURN is ignored.
- Masking a pending source keeps it pending. Unmasking it while in IDLE causes it to be taken on the next edge.
- ss_pc == SS_LIMIT does not trap. ss_pc = SS_LIMIT-1 does trap.
- Single-step asserted while in HANDLER/TAKE/RETURN is dropped, not queued.
- epc_we, flush and redirect_valid are never high for more than 1 consecutive cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles during an exc_req pulse → all outputs 0, pending=0, state IDLE after release.
- Priority: exc_req=3'b110 in one cycle with epc slices 0x100/0x104/0x108 → TAKE with cause=2 and epc=0x104. pending=3'b100 during HANDLER. After eret: RETURN redirect_pc=0x104, then a second TAKE with cause=3 and epc=0x108.
- Mask: exc_req[0] with exc_mask[0]=1 → no TAKE for 10 cycles, pending[0]=1. Clear the mask → TAKE 1 cycle later, cause=1, flush=1 for exactly one cycle.
- Single-step boundary: ss_en=1, ss_valid=1, ss_pc=399 → TAKE with cause=NUM_SRC+1=4, ss_trap=1, epc=399. Repeat with ss_pc=400 → no TAKE.
- No nesting: while in HANDLER pulse exc_req[0] and assert eret in the same cycle → RETURN occurs first; the exception is then taken from IDLE with cause=1.
- Reset mid-handler: in HANDLER with pending=3'b001, drop rst_n for 1 cycle → in_handler=0, pending=0, cause=0, no redirect after release.
